// File: rtl/median_frame_sequencer.sv
// median_frame_sequencer: walks an IMG_W x IMG_H frame in raster order, fetching 3x3 windows and writing back medians.
// Build option MEDIAN_ZERO_PAD_EN: out-of-frame taps skip the RAM read and feed zero instead of replicating the edge.
module median_frame_sequencer #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              win_valid,
  output logic [PIX_W-1:0]  win_pix,
  output logic              win_last,
  input  logic              med_valid,
  input  logic [PIX_W-1:0]  med_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);
  localparam int XW = $clog2(IMG_W) + 1;
  localparam int YW = $clog2(IMG_H) + 1;
  localparam int XS = XW + 1;
  localparam int YS = YW + 1;
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MED, WRITE, NEXT, DONE} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]        cx;
  logic [YW-1:0]        cy;
  logic [1:0]           tx, ty;
  logic signed [XS-1:0] sx_p0;
  logic signed [YS-1:0] sy_p0;
  logic [ADDR_W-1:0]    tap_addr_p0, rd_addr_q;
  logic                 vld_p0, last_p0, tap_pad_p0;
  logic                 vld_p1, last_p1, pad_p1;
  logic [PIX_W-1:0]     med_q;

  function automatic logic [XW-1:0] clamp_x(input logic signed [XS-1:0] v);
    if (v[XS-1]) return '0;
    else if (v > $signed({1'b0, X_LAST})) return X_LAST;
    else return v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic signed [YS-1:0] v);
    if (v[YS-1]) return '0;
    else if (v > $signed({1'b0, Y_LAST})) return Y_LAST;
    else return v[YW-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return ADDR_W'(y) * ROW_A + ADDR_W'(x);
  endfunction

  // p0: tap issue -- tap offset (tx-1, ty-1) applied as a signed add, then clamped
  always_comb begin
    sx_p0       = $signed({1'b0, cx}) + $signed({{(XS-2){1'b0}}, tx}) - $signed(XS'(1));
    sy_p0       = $signed({1'b0, cy}) + $signed({{(YS-2){1'b0}}, ty}) - $signed(YS'(1));
    tap_addr_p0 = pix_addr(clamp_x(sx_p0), clamp_y(sy_p0));
    vld_p0      = (state == FETCH);
    last_p0     = vld_p0 && (tx == 2'd2) && (ty == 2'd2);
`ifdef MEDIAN_ZERO_PAD_EN
    tap_pad_p0  = sx_p0[XS-1] || (sx_p0 > $signed({1'b0, X_LAST})) ||
                  sy_p0[YS-1] || (sy_p0 > $signed({1'b0, Y_LAST}));
`else
    tap_pad_p0  = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = FETCH;
      FETCH:    if (tx == 2'd2 && ty == 2'd2) state_nxt = WAIT_MED;
      WAIT_MED: if (med_valid) state_nxt = WRITE;
      WRITE:    state_nxt = NEXT;
      NEXT:     state_nxt = (cx == X_LAST && cy == Y_LAST) ? DONE : FETCH;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      tx        <= '0;
      ty        <= '0;
      rd_addr_q <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      pad_p1    <= 1'b0;
    end else begin
      state   <= state_nxt;
      // p1: tap presented to the sorter one cycle after issue, matching RAM read latency
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      pad_p1  <= vld_p0 && tap_pad_p0;
      if (rd_en) rd_addr_q <= tap_addr_p0;
      if (state == IDLE && start) begin
        cx <= '0;
        cy <= '0;
      end
      if (vld_p0) begin
        if (tx == 2'd2) begin
          tx <= '0;
          ty <= (ty == 2'd2) ? 2'd0 : ty + 2'd1;
        end else begin
          tx <= tx + 2'd1;
        end
      end
      if (state == NEXT) begin
        if (cx == X_LAST) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

  // Result is registered at acceptance so med_valid never reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (state == WAIT_MED && med_valid) med_q <= med_data;
  end

  always_comb begin
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    rd_en     = vld_p0 && !tap_pad_p0;
    rd_addr   = rd_en ? tap_addr_p0 : rd_addr_q;
    win_valid = vld_p1;
    win_last  = last_p1;
    win_pix   = (vld_p1 && !pad_p1) ? rd_data : '0;
    wr_en     = (state == WRITE);
    wr_addr   = wr_en ? pix_addr(cx, cy) : '0;
    wr_data   = wr_en ? med_q : '0;
  end
endmodule

// File: tb/tb_median_frame_sequencer.sv
`timescale 1ns/1ps
// tb_median_frame_sequencer: 4x4 frames with random RAM contents and sorter stalls, checked against a window/median model.
module tb_median_frame_sequencer;
  localparam int W = 4, H = 4, AW = 4, PW = 8, L = 2;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic          busy, done, rd_en, win_valid, win_last, wr_en;
  logic          med_valid = 1'b0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [PW-1:0] rd_data = '0, med_data = '0;
  logic [PW-1:0] win_pix, wr_data;

  int n_chk = 0, n_err = 0;
  int ram [W*H];
  int exp_rd[$], exp_tap[$], exp_wa[$], exp_wd[$];
  int s_taps[$];
  int cyc = 0, done_cnt = 0, wr_cnt = 0, win_idx = 0, cd = -1, e = 0;
  bit mon_en = 0, stall_en = 0, stall_first = 0;

  median_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .win_valid(win_valid), .win_pix(win_pix), .win_last(win_last),
    .med_valid(med_valid), .med_data(med_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int median9(input int v[$]);
    int a[9];
    int t;
    for (int i = 0; i < 9; i++) a[i] = (i < v.size()) ? v[i] : 0;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[4];
  endfunction

  // Reference: every pixel in raster order, its nine taps row-major, then the median write.
  task automatic build_frame();
    int v[$];
    int px, py, pv;
    exp_rd.delete(); exp_tap.delete(); exp_wa.delete(); exp_wd.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        v.delete();
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            px = x + dx;
            py = y + dy;
`ifdef MEDIAN_ZERO_PAD_EN
            if (px < 0 || px >= W || py < 0 || py >= H) pv = 0;
            else begin
              exp_rd.push_back(py * W + px);
              pv = ram[py * W + px];
            end
`else
            px = (px < 0) ? 0 : (px > W - 1) ? W - 1 : px;
            py = (py < 0) ? 0 : (py > H - 1) ? H - 1 : py;
            exp_rd.push_back(py * W + px);
            pv = ram[py * W + px];
`endif
            v.push_back(pv);
            exp_tap.push_back(pv);
          end
        exp_wa.push_back(y * W + x);
        exp_wd.push_back(median9(v));
      end
  endtask

  // Monitor, then the sorter and RAM stand-ins, all on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_en) begin
        e = (exp_rd.size() > 0) ? exp_rd.pop_front() : -1;
        check_eq("rd_addr", rd_addr, e);
      end
      if (win_valid) begin
        e = (exp_tap.size() > 0) ? exp_tap.pop_front() : -1;
        check_eq("win_pix", win_pix, e);
        check_eq("win_last", win_last, win_idx == 8);
        win_idx = (win_idx == 8) ? 0 : win_idx + 1;
      end
      if (med_valid) check_eq("wr_after_med", wr_en, 1);
      if (cd > 0) check_eq("stall_quiet", rd_en | wr_en, 0);
      if (wr_en) begin
        check_eq("wr_timing", med_valid, 1);
        e = (exp_wa.size() > 0) ? exp_wa.pop_front() : -1;
        check_eq("wr_addr", wr_addr, e);
        e = (exp_wd.size() > 0) ? exp_wd.pop_front() : -1;
        check_eq("wr_data", wr_data, e);
        wr_cnt++;
      end
      if (done) done_cnt++;
    end
    if (reset) begin
      s_taps.delete();
      cd = -1;
      med_valid = 1'b0;
    end else begin
      med_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin med_valid = 1'b1; cd = -1; end
      end
      if (win_valid) begin
        s_taps.push_back(int'(win_pix));
        if (win_last) begin
          med_data = PW'(median9(s_taps));
          s_taps.delete();
          cd = L - 1 + ((stall_en && (stall_first || $urandom_range(0, 3) == 0)) ? 20 : 0);
          stall_first = 0;
          if (cd == 0) begin med_valid = 1'b1; cd = -1; end
        end
      end
    end
    if (rd_en) rd_data = PW'(ram[rd_addr]);
  end

  task automatic outputs_zero(input string tag);
    check_eq(tag, {busy, done, rd_en, rd_addr, win_valid, win_pix, win_last, wr_en, wr_addr, wr_data}, 0);
  endtask

  // Called at a falling edge with the DUT idle; start is raised immediately.
  task automatic run_frame(input bit chk_len, input bit poke_start);
    int  s;
    bit  seen;
    build_frame();
    done_cnt = 0; wr_cnt = 0; win_idx = 0;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else start = poke_start && busy && ($urandom_range(0, 7) == 0);
    end
    check_eq("done_seen", seen, 1);
    if (chk_len) check_eq("frame_cycles", cyc - s, W * H * (11 + L) + 1);
    check_eq("busy_at_done", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_in_done_ignored", busy, 0);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("write_count", wr_cnt, W * H);
    check_eq("rd_left", exp_rd.size(), 0);
    check_eq("tap_left", exp_tap.size(), 0);
  endtask

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    outputs_zero("reset_hold");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      outputs_zero("idle");
    end

    for (int i = 0; i < W * H; i++) ram[i] = i;
    mon_en = 1;
    run_frame(1, 0);

    for (int i = 0; i < W * H; i++) ram[i] = int'($urandom_range(0, 255));
    stall_en = 1;
    stall_first = 1;
    run_frame(0, 1);
    stall_en = 0;

    // Abort during pixel 6's fetch, then restart from scratch.
    for (int i = 0; i < W * H; i++) ram[i] = int'($urandom_range(0, 255));
    build_frame();
    done_cnt = 0; wr_cnt = 0; win_idx = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (wr_cnt >= 6 && rd_en) hit = 1;
    end
    check_eq("reached_pixel6_fetch", hit, 1);
    @(negedge clk);
    reset = 1'b1;
    mon_en = 0;
    @(negedge clk);
    outputs_zero("reset_mid_frame");
    @(negedge clk);
    reset = 1'b0;
    exp_rd.delete(); exp_tap.delete(); exp_wa.delete(); exp_wd.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      outputs_zero("after_abort");
    end
    mon_en = 1;
    for (int i = 0; i < W * H; i++) ram[i] = int'($urandom_range(0, 255));
    run_frame(1, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end
endmodule
